// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and state encoding for the SHA-256 message padder
package sha256_pkg;

  localparam int SHA_BLOCK_W   = 512;
  localparam int SHA_DIGEST_W  = 256;
  localparam int BLK_BYTES     = SHA_BLOCK_W / 8;
  localparam int LEN_FIELD_OFS = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_PAD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4
  } pad_state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - byte-stream and block-core signals of the padder
// SHA_PAD_DIGEST_CAPTURE_EN adds the digest capture signals.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic [7:0]             i_Byte;
  logic                   i_fValid;
  logic                   i_fLast;
  logic                   o_fReady;
  logic [SHA_BLOCK_W-1:0] o_Data;
  logic                   o_fStart;
  logic                   o_fFirst;
  logic                   i_fDone;
  logic                   o_fMsgDone;
  logic                   o_fErr;

`ifdef SHA_PAD_DIGEST_CAPTURE_EN
  logic [SHA_DIGEST_W-1:0] i_Digest;
  logic [SHA_DIGEST_W-1:0] o_Digest;
  logic                    o_fDigestValid;

  modport slave (
    input  i_Byte, i_fValid, i_fLast, i_fDone, i_Digest,
    output o_fReady, o_Data, o_fStart, o_fFirst, o_fMsgDone, o_fErr, o_Digest, o_fDigestValid
  );
  modport master (
    output i_Byte, i_fValid, i_fLast, i_fDone, i_Digest,
    input  o_fReady, o_Data, o_fStart, o_fFirst, o_fMsgDone, o_fErr, o_Digest, o_fDigestValid
  );
`else
  modport slave (
    input  i_Byte, i_fValid, i_fLast, i_fDone,
    output o_fReady, o_Data, o_fStart, o_fFirst, o_fMsgDone, o_fErr
  );
  modport master (
    output i_Byte, i_fValid, i_fLast, i_fDone,
    input  o_fReady, o_Data, o_fStart, o_fFirst, o_fMsgDone, o_fErr
  );
`endif

endinterface

// File: rtl/sha256_blk_buf.sv
// rtl/sha256_blk_buf.sv - 64x8 block buffer, single-byte write, 8-byte length write, 512-bit read
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic                   Clk,
  input  logic                   wr_en,
  input  logic [5:0]             wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   len_en,
  input  logic [63:0]            len_data,
  output logic [SHA_BLOCK_W-1:0] rd_data
);

  logic [7:0] mem [BLK_BYTES];

  // Every byte of a block is rewritten before it is sent, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (len_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[6'(LEN_FIELD_OFS + i)] <= len_data[63 - 8*i -: 8];
      end
    end
  end

  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_rd
    assign rd_data[SHA_BLOCK_W - 1 - 8*g -: 8] = mem[g];
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 byte-stream padder feeding the SHA-256 block core
// SHA_PAD_DIGEST_CAPTURE_EN enables capture of the core digest at message end.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic               Clk,
  input  logic               Rst,
  sha256_msg_padder_if.slave bus
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  pad_state_t             state_q, state_d;
  logic [6:0]             ptr_q, ptr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W:0]         len_sum;
  logic [TMO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   first_q, first_d;
  logic                   need80_q, need80_d;
  logic                   pad_pend_q, pad_pend_d;
  logic                   final_q, final_d;
  logic                   err_q, err_d;
  logic                   msg_done_q, msg_done_d;
  logic                   rdy_en_q;
  logic [SHA_BLOCK_W-1:0] data_q, blk_rd;
  logic                   wr_en, len_en, ready, start, first_out, timed_out;
  logic [7:0]             wr_data;
  logic [63:0]            len_field;

  assign len_sum   = {1'b0, len_q} + (LEN_W + 1)'(8);
  assign len_field = 64'(len_q);
  assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == TMO_W'(TIMEOUT));

  sha256_blk_buf u_buf (
    .Clk      (Clk),
    .wr_en    (wr_en),
    .wr_addr  (ptr_q[5:0]),
    .wr_data  (wr_data),
    .len_en   (len_en),
    .len_data (len_field),
    .rd_data  (blk_rd)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_FILL;
      ptr_q      <= '0;
      len_q      <= '0;
      wait_cnt_q <= '0;
      first_q    <= 1'b1;
      need80_q   <= 1'b0;
      pad_pend_q <= 1'b0;
      final_q    <= 1'b0;
      err_q      <= 1'b0;
      msg_done_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      wait_cnt_q <= wait_cnt_d;
      first_q    <= first_d;
      need80_q   <= need80_d;
      pad_pend_q <= pad_pend_d;
      final_q    <= final_d;
      err_q      <= err_d;
      msg_done_q <= msg_done_d;
      rdy_en_q   <= 1'b1;
      if (state_q == ST_SEND) begin
        data_q <= blk_rd;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    wait_cnt_d = wait_cnt_q;
    first_d    = first_q;
    need80_d   = need80_q;
    pad_pend_d = pad_pend_q;
    final_d    = final_q;
    err_d      = err_q;
    msg_done_d = 1'b0;
    wr_en      = 1'b0;
    wr_data    = bus.i_Byte;
    len_en     = 1'b0;
    ready      = 1'b0;
    start      = 1'b0;
    first_out  = 1'b0;

    case (state_q)
      ST_FILL: begin
        ready = rdy_en_q;
        if (rdy_en_q && bus.i_fValid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 7'd1;
          len_d = len_sum[LEN_W-1:0];
          if (len_sum[LEN_W]) begin
            err_d = 1'b1;
          end
          if (bus.i_fLast) begin
            need80_d = 1'b1;
            // Last byte fills the block: the 0x80 goes into a fresh block after this one.
            if (ptr_q == 7'd63) begin
              pad_pend_d = 1'b1;
              state_d    = ST_SEND;
            end else begin
              state_d = ST_PAD;
            end
          end else if (ptr_q == 7'd63) begin
            state_d = ST_SEND;
          end
        end
      end

      ST_PAD: begin
        wr_en    = 1'b1;
        wr_data  = need80_q ? PAD_BYTE : 8'h00;
        need80_d = 1'b0;
        ptr_d    = ptr_q + 7'd1;
        if (ptr_q == 7'(LEN_FIELD_OFS - 1)) begin
          state_d = ST_LEN;
        end else if (ptr_q == 7'd63) begin
          pad_pend_d = 1'b1;
          state_d    = ST_SEND;
        end
      end

      ST_LEN: begin
        len_en  = 1'b1;
        final_d = 1'b1;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        start      = 1'b1;
        first_out  = first_q;
        first_d    = 1'b0;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.i_fDone) begin
          ptr_d = '0;
          if (final_q) begin
            msg_done_d = 1'b1;
            len_d      = '0;
            first_d    = 1'b1;
            final_d    = 1'b0;
            state_d    = ST_FILL;
          end else if (pad_pend_q) begin
            pad_pend_d = 1'b0;
            state_d    = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end else if (timed_out) begin
          // Core went silent: drop the whole message and wait for a new one.
          err_d      = 1'b1;
          ptr_d      = '0;
          len_d      = '0;
          first_d    = 1'b1;
          final_d    = 1'b0;
          pad_pend_d = 1'b0;
          need80_d   = 1'b0;
          state_d    = ST_FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // The SEND cycle shows the buffer directly; data_q holds it until the next SEND.
  assign bus.o_Data     = (state_q == ST_SEND) ? blk_rd : data_q;
  assign bus.o_fReady   = ready;
  assign bus.o_fStart   = start;
  assign bus.o_fFirst   = first_out;
  assign bus.o_fMsgDone = msg_done_q;
  assign bus.o_fErr     = err_q;

`ifdef SHA_PAD_DIGEST_CAPTURE_EN
  logic [SHA_DIGEST_W-1:0] digest_q;
  logic                    digest_vld_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      digest_q     <= '0;
      digest_vld_q <= 1'b0;
    end else if (state_q == ST_WAIT && bus.i_fDone && final_q) begin
      digest_q     <= bus.i_Digest;
      digest_vld_q <= 1'b1;
    end else if (start && first_q) begin
      digest_vld_q <= 1'b0;
    end
  end

  assign bus.o_Digest       = digest_q;
  assign bus.o_fDigestValid = digest_vld_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - self-checking bench for sha256_msg_padder
module tb_sha256_msg_padder;

  localparam int TMO = 100;

  logic clk;
  logic rst;
  int   n_err    = 0;
  int   n_checks = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   msg_done_cnt = 0;
  int   start_cnt    = 0;
  bit   core_auto = 1;
  bit   spur_en   = 0;
  logic err_exp   = 0;

  logic [511:0] got_data[$];
  logic         got_first[$];
  int           got_cyc[$];

  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.LEN_W(64), .TIMEOUT(TMO)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_fStart) begin
      got_data.push_back(bus.o_Data);
      got_first.push_back(bus.o_fFirst);
      got_cyc.push_back(cyc);
      start_cnt++;
    end
    if (bus.o_fMsgDone) msg_done_cnt++;
  end

  // Core model: answer each block after a random delay, optionally with stray dones when idle.
  initial begin
    int cnt;
    cnt = -1;
    bus.i_fDone = 0;
    forever begin
      @(negedge clk);
      bus.i_fDone = 0;
      if (rst) cnt = -1;
      else if (bus.o_fStart && core_auto) cnt = int'($urandom_range(0, 5));
      else if (cnt > 0) cnt--;
      else if (cnt == 0) begin bus.i_fDone = 1; cnt = -1; end
      else if (spur_en && core_auto && $urandom_range(0, 9) == 0) bus.i_fDone = 1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void pad_ref(input logic [7:0] m[$], output logic [511:0] blks[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    blks.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      blks.push_back(blk);
    end
  endfunction

  task automatic send_bytes(input logic [7:0] m[$], input int gap_pct);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < m.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        bus.i_fValid = 0;
        bus.i_fLast  = 0;
      end else begin
        bus.i_fValid = 1;
        bus.i_Byte   = m[i];
        bus.i_fLast  = (i == m.size() - 1);
        if (bus.o_fReady) begin
          if (i == m.size() - 1) last_cyc = cyc;
          i++;
        end
      end
    end
    @(negedge clk);
    bus.i_fValid = 0;
    bus.i_fLast  = 0;
    chk("send_bytes_all_taken", i, m.size());
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (msg_done_cnt == prev && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_msg_done", msg_done_cnt, prev + 1);
  endtask

  task automatic run_msg(input logic [7:0] m[$], input string tag, input int gap_pct);
    logic [511:0] exp_q[$];
    int prev;
    got_data.delete();
    got_first.delete();
    got_cyc.delete();
    prev = msg_done_cnt;
    send_bytes(m, gap_pct);
    wait_done(prev);
    repeat (3) @(negedge clk);
    pad_ref(m, exp_q);
    chk({tag, "_nblk"}, got_data.size(), exp_q.size());
    chk({tag, "_done_cnt"}, msg_done_cnt, prev + 1);
    for (int b = 0; b < exp_q.size() && b < got_data.size(); b++) begin
      chk($sformatf("%s_blk%0d", tag, b), got_data[b], exp_q[b]);
      chk($sformatf("%s_first%0d", tag, b), got_first[b], (b == 0));
    end
    if (got_data.size() > 0) chk({tag, "_hold"}, bus.o_Data, got_data[got_data.size() - 1]);
    chk({tag, "_err"}, bus.o_fErr, err_exp);
  endtask

  typedef struct {
    int          len;
    int          seed;
    int          exp_blocks;
    logic [31:0] exp_len_word;
  } vec_t;

  initial begin
    vec_t         vecs[9];
    logic [7:0]   m[$];
    logic [511:0] e;
    string        s;
    int           n, s0;

    vecs[0] = '{1,   5,  1, 32'd8};
    vecs[1] = '{55,  9,  1, 32'd440};
    vecs[2] = '{56,  3,  2, 32'd448};
    vecs[3] = '{63,  11, 2, 32'd504};
    vecs[4] = '{64,  2,  2, 32'd512};
    vecs[5] = '{65,  7,  2, 32'd520};
    vecs[6] = '{119, 1,  2, 32'd952};
    vecs[7] = '{120, 4,  3, 32'd960};
    vecs[8] = '{128, 6,  3, 32'd1024};

    rst = 1;
    bus.i_Byte   = 0;
    bus.i_fValid = 0;
    bus.i_fLast  = 0;
`ifdef SHA_PAD_DIGEST_CAPTURE_EN
    bus.i_Digest = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.o_fReady, 0);
    chk("rst_start", bus.o_fStart, 0);
    chk("rst_first", bus.o_fFirst, 0);
    chk("rst_msgdone", bus.o_fMsgDone, 0);
    chk("rst_err", bus.o_fErr, 0);
    chk("rst_data", bus.o_Data, 0);
    rst = 0;
    #1 chk("rst_release_ready_low", bus.o_fReady, 0);
    @(negedge clk);
    chk("rst_release_ready_high", bus.o_fReady, 1);

    // "abc": single block, exact contents and last-byte-to-start latency.
    m = '{8'h61, 8'h62, 8'h63};
`ifdef SHA_PAD_DIGEST_CAPTURE_EN
    bus.i_Digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
`endif
    run_msg(m, "abc", 0);
    e = '0;
    e[511:480] = 32'h61626380;
    e[31:0]    = 32'h00000018;
    if (got_data.size() > 0) begin
      chk("abc_const", got_data[0], e);
      chk("abc_latency", got_cyc[0] - last_cyc, 55);
    end
`ifdef SHA_PAD_DIGEST_CAPTURE_EN
    chk("abc_digest", bus.o_Digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    chk("abc_digest_valid", bus.o_fDigestValid, 1);
`endif

    // 56-byte message: 0x80 lands in the first block, length alone in the second.
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    run_msg(m, "m56", 20);
    if (got_data.size() >= 2) begin
      chk("m56_blk1_tail", got_data[0][95:0], 96'h6e6f7071_80000000_00000000);
      e = '0;
      e[31:0] = 32'h000001c0;
      chk("m56_blk2_const", got_data[1], e);
    end

    // 64 zero bytes: full data block, then a block starting with the single 0x80.
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'h00);
    run_msg(m, "z64", 10);
    if (got_data.size() >= 2) begin
      chk("z64_blk1_const", got_data[0], 512'h0);
      e = '0;
      e[511:504] = 8'h80;
      e[31:0]    = 32'h00000200;
      chk("z64_blk2_const", got_data[1], e);
    end

    for (int v = 0; v < 9; v++) begin
      m.delete();
      for (int i = 0; i < vecs[v].len; i++) m.push_back(8'(i * 7 + vecs[v].seed));
      run_msg(m, $sformatf("vec%0d", v), 15);
      chk($sformatf("vec%0d_blocks", v), got_data.size(), vecs[v].exp_blocks);
      if (got_data.size() > 0)
        chk($sformatf("vec%0d_lenword", v), got_data[got_data.size() - 1][31:0], vecs[v].exp_len_word);
    end

    spur_en = 1;
    for (int r = 0; r < 12; r++) begin
      m.delete();
      n = int'($urandom_range(1, 150));
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      run_msg(m, $sformatf("rnd%0d", r), 30);
    end
    spur_en = 0;

    // Done timeout: core never answers.
    core_auto = 0;
    m = '{8'h61, 8'h62, 8'h63};
    s0 = msg_done_cnt;
    send_bytes(m, 0);
    n = 0;
    while (!bus.o_fStart && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_start_seen", bus.o_fStart, 1);
    repeat (TMO) @(negedge clk);
    chk("tmo_err_before", bus.o_fErr, 0);
    repeat (3) @(negedge clk);
    chk("tmo_err_after", bus.o_fErr, 1);
    chk("tmo_ready", bus.o_fReady, 1);
    chk("tmo_no_msgdone", msg_done_cnt, s0);
    core_auto = 1;
    err_exp = 1;
    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_msg(m, "post_tmo", 0);

    // Reset in the middle of padding.
    m = '{8'h11, 8'h22};
    send_bytes(m, 0);
    repeat (10) @(negedge clk);
    s0 = start_cnt;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("midpad_ready_low", bus.o_fReady, 0);
    chk("midpad_err_clear", bus.o_fErr, 0);
    chk("midpad_start", bus.o_fStart, 0);
    chk("midpad_data", bus.o_Data, 512'h0);
    @(negedge clk);
    chk("midpad_ready_high", bus.o_fReady, 1);
    chk("midpad_no_start", start_cnt, s0);
    err_exp = 0;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, "post_rst", 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
